// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, wrapping range of register-file words out on a
// valid/ready port, tagging each word with its address and a last flag.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  RD,
    output logic [ADDR_WIDTH-1:0] sel_o1,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   curAddr_q, curAddr_d;
    logic [ADDR_WIDTH:0]     remain_q, remain_d;
    logic [ADDR_WIDTH-1:0]   selHold_q;

    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   inflightAddr_q;
    logic                    inflightLast_q;

    logic [DATA_WIDTH-1:0]   fifoData_q [2];
    logic [ADDR_WIDTH-1:0]   fifoAddr_q [2];
    logic                    fifoLast_q [2];
    logic                    wrPtr_q, rdPtr_q;
    logic [1:0]              occ_q;

    logic                    pop;
    logic                    push;
    logic [2:0]              level;
    logic                    rdEn;
    logic                    issueLast;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = fifoData_q[rdPtr_q];
    assign m_addr    = fifoAddr_q[rdPtr_q];
    assign m_last    = fifoLast_q[rdPtr_q];
    assign pop       = m_valid & m_ready;
    assign push      = inflight_q;

    // Slots already committed (buffered or in flight) after this cycle's pop;
    // keeping this below 2 means the 2-entry buffer can never overflow.
    assign level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rdEn      = (state_q == ISSUE) && (level < 3'd2);
    assign issueLast = (remain_q == (ADDR_WIDTH+1)'(1));

    assign RD        = rdEn;
    assign sel_o1    = rdEn ? curAddr_q : selHold_q;
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == FIN);

    always_comb begin
        state_d   = state_q;
        curAddr_d = curAddr_q;
        remain_d  = remain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    curAddr_d = first_addr;
                    remain_d  = count;
                    state_d   = (count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (rdEn) begin
                    curAddr_d = curAddr_q + ADDR_WIDTH'(1);
                    remain_d  = remain_q - (ADDR_WIDTH+1)'(1);
                    if (issueLast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            curAddr_q      <= '0;
            remain_q       <= '0;
            selHold_q      <= '0;
            inflight_q     <= 1'b0;
            inflightAddr_q <= '0;
            inflightLast_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            curAddr_q      <= curAddr_d;
            remain_q       <= remain_d;
            selHold_q      <= sel_o1;
            inflight_q     <= rdEn;
            if (rdEn) begin
                inflightAddr_q <= sel_o1;
                inflightLast_q <= issueLast;
            end
        end
    end

    // The file's registered op1 lands one edge after the read, so the
    // in-flight tag registered alongside it is paired with rf_data here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifoData_q[i] <= '0;
                fifoAddr_q[i] <= '0;
                fifoLast_q[i] <= 1'b0;
            end
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= rf_data;
                fifoAddr_q[wrPtr_q] <= inflightAddr_q;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file
// whose op1 output is registered one cycle after the read.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  first_addr;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic        RD;
    logic [3:0]  sel_o1;
    logic [31:0] rf_data;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_addr;
    logic        m_last;
    logic        m_ready;

    logic [31:0] mem [16];

    int checkCount = 0;
    int passCount  = 0;

    logic [3:0]  beatAddr [$];
    logic [31:0] beatData [$];
    logic        beatLast [$];
    int          beatCyc  [$];

    int stallViol, rdViol, addrViol, busyViol, donePulseViol;
    int doneSeen, doneCyc, firstValidCyc, validSeen, rdTotal;

    typedef struct {
        logic [3:0]  first;
        logic [4:0]  cnt;
        int          mode;
        bit          midStart;
        logic [31:0] reg0;
        logic [31:0] expFirst;
    } dumpVec_t;

    dumpVec_t vecs [8];

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .RD         (RD),
        .sel_o1     (sel_o1),
        .rf_data    (rf_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read port: op1 is registered on the edge that samples RD.
    always @(posedge clk) begin
        if (RD) rf_data <= mem[sel_o1];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic readyFor(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
            default: return (cyc % 4 == 3);
        endcase
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".busy"},    busy,    0);
        checkOutput({tag, ".done"},    done,    0);
        checkOutput({tag, ".RD"},      RD,      0);
        checkOutput({tag, ".sel_o1"},  sel_o1,  0);
        checkOutput({tag, ".m_valid"}, m_valid, 0);
        checkOutput({tag, ".m_data"},  m_data,  0);
        checkOutput({tag, ".m_addr"},  m_addr,  0);
        checkOutput({tag, ".m_last"},  m_last,  0);
    endtask

    // Runs one dump; cycle 0 is the cycle right after the start edge.
    task automatic applyStimulus(input logic [3:0] f, input logic [4:0] c, input int mode, input bit midStart);
        int          issued, popped;
        logic        prevStall, popNow;
        logic [31:0] pd;
        logic [3:0]  pa;
        logic        pl;
        beatAddr.delete(); beatData.delete(); beatLast.delete(); beatCyc.delete();
        stallViol = 0; rdViol = 0; addrViol = 0; busyViol = 0; donePulseViol = 0;
        doneSeen = 0; doneCyc = -1; firstValidCyc = -1; validSeen = 0; rdTotal = 0;
        issued = 0; popped = 0; prevStall = 1'b0; pd = '0; pa = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1; first_addr = f; count = c;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            m_ready = readyFor(mode, cyc);
            if (midStart && cyc == 3) begin
                start = 1'b1; first_addr = 4'd9; count = 5'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            if (doneSeen != 0) begin
                if (done) donePulseViol++;
                break;
            end
            if (prevStall && (!m_valid || m_data !== pd || m_addr !== pa || m_last !== pl)) stallViol++;
            popNow = m_valid && m_ready;
            if (RD) begin
                rdTotal++;
                if (issued - popped - (popNow ? 1 : 0) >= 2) rdViol++;
                if (sel_o1 !== f + 4'(issued)) addrViol++;
                issued++;
            end
            if (m_valid) begin
                validSeen = 1;
                if (firstValidCyc < 0) firstValidCyc = cyc;
            end
            if (popNow) begin
                beatAddr.push_back(m_addr);
                beatData.push_back(m_data);
                beatLast.push_back(m_last);
                beatCyc.push_back(cyc);
                popped++;
            end
            if (done) begin
                doneSeen = 1;
                doneCyc = cyc;
                if (busy) busyViol++;
            end else if (c != 0 && !busy) begin
                busyViol++;
            end
            prevStall = m_valid && !m_ready;
            pd = m_data; pa = m_addr; pl = m_last;
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic verifyDump(input logic [3:0] f, input logic [4:0] c, input int mode, input logic [31:0] expFirst);
        int          errs;
        int          n;
        logic [3:0]  ea;
        checkOutput("beatCount", beatAddr.size(), c);
        if (c != 0) begin
            errs = 0;
            n = (beatAddr.size() < int'(c)) ? beatAddr.size() : int'(c);
            for (int i = 0; i < n; i++) begin
                ea = f + 4'(i);
                if (beatAddr[i] !== ea || beatData[i] !== mem[ea] || beatLast[i] !== (i == int'(c) - 1)) errs++;
            end
            checkOutput("beatContents", errs, 0);
            if (beatData.size() > 0) begin
                checkOutput("firstData", beatData[0], expFirst);
                checkOutput("doneAfterLast", doneCyc - beatCyc[beatCyc.size()-1], 1);
                if (mode == 0) checkOutput("throughput", beatCyc[beatCyc.size()-1] - beatCyc[0], int'(c) - 1);
            end
            checkOutput("firstValidLatency", firstValidCyc, 2);
            checkOutput("rdTotal", rdTotal, c);
        end else begin
            checkOutput("zeroDoneCycle", doneCyc, 0);
            checkOutput("zeroNoRd", rdTotal, 0);
            checkOutput("zeroNoValid", validSeen, 0);
        end
        checkOutput("stallStable", stallViol, 0);
        checkOutput("rdRule", rdViol, 0);
        checkOutput("rdAddr", addrViol, 0);
        checkOutput("busyFlag", busyViol, 0);
        checkOutput("donePulseLen", donePulseViol, 0);
        checkOutput("doneSeen", doneSeen, 1);
    endtask

    initial begin
        int popCount;
        int doneDuringReset;
        rst = 1'b0; start = 1'b0; first_addr = '0; count = '0; m_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h101;
        mem[0]  = 32'habcd_efab;
        mem[1]  = 32'h7777_7777;
        mem[2]  = 32'h0643_0028;
        mem[3]  = 32'h1122_88bb;
        mem[14] = 32'hface_cafe;

        vecs[0] = '{4'd0,  5'd4,  0, 1'b0, 32'habcd_efab, 32'habcd_efab};
        vecs[1] = '{4'd0,  5'd4,  1, 1'b0, 32'habcd_efab, 32'habcd_efab};
        vecs[2] = '{4'd14, 5'd4,  0, 1'b0, 32'hcade_bead, 32'hface_cafe};
        vecs[3] = '{4'd0,  5'd0,  0, 1'b0, 32'hcade_bead, 32'h0};
        vecs[4] = '{4'd5,  5'd16, 0, 1'b0, 32'hcade_bead, 32'h1000_0505};
        vecs[5] = '{4'd5,  5'd16, 2, 1'b0, 32'hcade_bead, 32'h1000_0505};
        vecs[6] = '{4'd2,  5'd5,  1, 1'b1, 32'hcade_bead, 32'h0643_0028};
        vecs[7] = '{4'd9,  5'd1,  0, 1'b0, 32'hcade_bead, 32'h1000_0909};

        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            mem[0] = vecs[v].reg0;
            $display("[TB] vector %0d: first=%0d count=%0d mode=%0d", v, vecs[v].first, vecs[v].cnt, vecs[v].mode);
            applyStimulus(vecs[v].first, vecs[v].cnt, vecs[v].mode, vecs[v].midStart);
            verifyDump(vecs[v].first, vecs[v].cnt, vecs[v].mode, vecs[v].expFirst);
            if (v == 0) begin
                checkOutput("plan.word1", beatData.size() > 1 ? beatData[1] : 32'h0, 32'h7777_7777);
                checkOutput("plan.word3", beatData.size() > 3 ? beatData[3] : 32'h0, 32'h1122_88bb);
            end
            if (v == 2) begin
                checkOutput("wrap.addr2", beatAddr.size() > 2 ? beatAddr[2] : 4'hf, 4'd0);
                checkOutput("wrap.data2", beatData.size() > 2 ? beatData[2] : 32'h0, 32'hcade_bead);
            end
        end

        // Reset in the middle of a dump, after two beats have been taken.
        $display("[TB] mid-dump reset sequence");
        @(negedge clk);
        start = 1'b1; first_addr = 4'd0; count = 5'd8; m_ready = 1'b1;
        popCount = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) popCount++;
        end
        checkOutput("preResetBeats", popCount, 2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkResetOutputs("midReset");
        rst = 1'b1;
        doneDuringReset = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            #1;
            if (done || m_valid || busy) doneDuringReset++;
        end
        checkOutput("noDoneAfterReset", doneDuringReset, 0);

        applyStimulus(4'd10, 5'd3, 0, 1'b0);
        verifyDump(4'd10, 5'd3, 0, 32'h1000_0a0a);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
